// File: rtl/m_wishbone_pkg.sv
// Shared definitions for the Wishbone classic-cycle master.
//   wb_state_t      : master FSM states (IDLE -> ACTIVE -> RESP -> IDLE)
//   ADR_INC         : byte-address step between beats of a block (one 32-bit word)
//   IDLEDAT_DEFAULT : value parked on DAT_O whenever no write strobe is active
package m_wishbone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } wb_state_t;

  localparam logic [31:0] ADR_INC         = 32'd4;
  localparam logic [31:0] IDLEDAT_DEFAULT = 32'hd0d0_d0d0;

endpackage

// File: rtl/m_wb_timeout.sv
// Per-beat wait counter for the Wishbone master.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the count (new command accepted or beat acknowledged)
//   enable   : count one more wait cycle (strobe high, no acknowledge)
//   expire   : count has reached TIMEOUT-1; a beat still unacknowledged in
//              this cycle has now waited TIMEOUT cycles
// With TIMEOUT == 0 the counter is not built and expire is tied low.
module m_wb_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable) begin
        count <= count + 1'b1;
      end
    end

    assign expire = (count == LIMIT);
  end

endmodule

// File: rtl/m_wishbonemaster.sv
// Wishbone B.4 classic-cycle 32-bit master with byte selects.
// One command (single or block, read or write) is taken on a valid/ready port
// and executed as a single CYC_O cycle; read data is returned beat by beat and
// a final response reports completion or timeout.
//
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready
// are both high; cmd_ready is high only in IDLE. rd_valid and rsp_valid are
// single-cycle pulses with no back-pressure.
//
// Ports:
//   CLK_I, RST_I           : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    : command handshake
//   cmd_we                 : 1 = write, 0 = read
//   cmd_adr                : byte address of first beat
//   cmd_sel                : byte selects for every beat
//   cmd_dat                : write data, repeated on every beat
//   cmd_len                : number of beats minus one
//   rd_valid, rd_data      : per-beat read return
//   rsp_valid, rsp_err     : command finished; err = beat timed out
//   CYC_O STB_O WE_O SEL_O ADR_O DAT_O : Wishbone master outputs
//   ACK_I DAT_I            : Wishbone master inputs
//   fsm_state              : current FSM state, for observation
import m_wishbone_pkg::*;

module m_wishbonemaster #(
  parameter int          LENW    = 4,
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] IDLEDAT = IDLEDAT_DEFAULT
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [31:0]     cmd_adr,
  input  logic [3:0]      cmd_sel,
  input  logic [31:0]     cmd_dat,
  input  logic [LENW-1:0] cmd_len,
  output logic            rd_valid,
  output logic [31:0]     rd_data,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic            CYC_O,
  output logic            STB_O,
  output logic            WE_O,
  output logic [3:0]      SEL_O,
  output logic [31:0]     ADR_O,
  output logic [31:0]     DAT_O,
  input  logic            ACK_I,
  input  logic [31:0]     DAT_I,
  output wb_state_t       fsm_state
);

  wb_state_t       state;
  wb_state_t       state_next;
  logic [31:0]     wdat;
  logic [LENW-1:0] count;
  logic            accept;
  logic            ack_take;
  logic            last_beat;
  logic            expire;
  logic            timed_out;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  // ACK_I only means something while our strobe is up; a slave holding ACK
  // high outside a strobe is ignored.
  assign ack_take  = STB_O & ACK_I;
  assign last_beat = (count == '0);
  assign timed_out = STB_O & ~ACK_I & expire;
  assign DAT_O     = (STB_O & WE_O) ? wdat : IDLEDAT;
  assign fsm_state = state;

  m_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (CLK_I),
    .rst    (RST_I),
    .clear  (accept | ack_take),
    .enable (STB_O & ~ACK_I),
    .expire (expire)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_ACTIVE;
      ST_ACTIVE: if ((ack_take && last_beat) || timed_out) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Registered Wishbone and response outputs. The response pulse is raised on
  // the same edge that ends the cycle, so it lines up with the final rd_valid.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      WE_O      <= 1'b0;
      SEL_O     <= '0;
      ADR_O     <= '0;
      wdat      <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          CYC_O <= 1'b1;
          STB_O <= 1'b1;
          WE_O  <= cmd_we;
          SEL_O <= cmd_sel;
          ADR_O <= cmd_adr;
          wdat  <= cmd_dat;
          count <= cmd_len;
        end
      end else if (state == ST_ACTIVE) begin
        if (ack_take) begin
          if (!WE_O) begin
            rd_valid <= 1'b1;
            rd_data  <= DAT_I;
          end
          if (last_beat) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            WE_O      <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            ADR_O <= ADR_O + ADR_INC;
            count <= count - 1'b1;
          end
        end else if (timed_out) begin
          CYC_O     <= 1'b0;
          STB_O     <= 1'b0;
          WE_O      <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule
